regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
// - Shares the single register-file write port between two writeback requesters:
//   EXE (ALU result) and MEM (load data).
// - Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.
// - Drives reg_write / write_addr / write_data into the register file from registers.
// - Sits between execute/memory stages and the register file; decode queries busy bits.
// PARAMETERS
// - DATA_W    32  writeback data width
// - ADDR_W    5   register index width
// - NUM_REGS  32  architectural registers; x0 is hard-wired zero
// - CNT_W     2   per-register outstanding-write counter width (max 2**CNT_W-1)
// PORTS
// - clk         in   1       clock, rising edge
// - reset       in   1       synchronous, active-high
// - issue_valid in   1       decode issues an instruction that writes rd
// - issue_rd    in   ADDR_W  destination of the issued instruction
// - issue_ready out  1       0 when issue_rd counter is saturated
// - rs1_addr    in   ADDR_W  decode source 1 index
// - rs2_addr    in   ADDR_W  decode source 2 index
// - rs1_busy    out  1       rs1_addr has a pending write
// - rs2_busy    out  1       rs2_addr has a pending write
// - exe_valid   in   1       EXE writeback request
// - exe_rd      in   ADDR_W  EXE destination
// - exe_data    in   DATA_W  EXE result
// - exe_ready   out  1       EXE request accepted this cycle
// - mem_valid   in   1       MEM writeback request
// - mem_rd      in   ADDR_W  MEM destination
// - mem_data    in   DATA_W  load data
// - mem_ready   out  1       MEM request accepted this cycle
// - reg_write   out  1       register-file write enable (1-cycle pulse per write)
// - write_addr  out  ADDR_W  register-file write index
// - write_data  out  DATA_W  register-file write data
// BEHAVIOUR
// - Reset: reg_write=0, write_addr=0, write_data=0, all counters=0, rr_last=MEM
//   (EXE wins first tie). Reset mid-operation drops any held write; nothing written.
// - Handshake: request accepted when valid && ready in the same cycle. Ready is
//   combinational (grant), never asserted without valid. At most one grant per cycle.
// - Arbitration: single requester -> granted. Both valid -> round-robin: grant the one
//   not granted last; rr_last updates only on a grant.
// - Latency: accepted request appears on reg_write/write_addr/write_data exactly 1 cycle
//   later; outputs registered. Back-to-back accepts give back-to-back write pulses.
// - x0: request with rd=0 is accepted normally but produces reg_write=0 that cycle;
//   issue with rd=0 is accepted, never counted; rs*_busy for index 0 is always 0.
// - Scoreboard: cnt[r] += 1 on issue_valid && issue_ready to r; cnt[r] -= 1 on the cycle
//   reg_write=1 with write_addr=r. Both same cycle, same r -> cnt unchanged.
// - issue_ready = (cnt[issue_rd] != max) || retiring issue_rd this cycle.
// - rsN_busy = (cnt[rsN_addr] != 0), from registered counters; no same-cycle bypass of
//   the retiring write (conservative, one extra stall cycle).
// - Retire on a counter already at 0 (protocol error): counter stays 0, never wraps.
// - Requesters must hold valid/rd/data stable until accepted.
// STRUCTURE
// - Shared package: DATA_W/ADDR_W/NUM_REGS defaults, X0 index constant, requester ids
//   (REQ_EXE=0, REQ_MEM=1).
// - One sub-module: wb_rr_arbiter (2-way round-robin, grant + rr_last register).
// - Scoreboard counters and output register inline in this module.
// TESTING
// - Reset then exe_valid, rd=5, data=32'hDEADBEEF -> exe_ready=1; next cycle reg_write=1,
//   write_addr=5, write_data=32'hDEADBEEF; following cycle reg_write=0.
// - exe and mem valid every cycle (rd 3/4) -> grants alternate EXE,MEM,EXE,MEM from
//   reset; each stalled requester's ready=0 while held.
// - Issue rd=7 -> rs1_addr=7 busy=1 next cycle; writeback rd=7 -> busy=0 the cycle after
//   the write pulse.
// - Issue rd=9 three times -> issue_ready=0 on 4th; retire + issue same cycle -> count 3.
// - exe rd=0 data=32'h1 -> exe_ready=1, reg_write stays 0; rs2_addr=0 busy=0 always.
// - Accept MEM rd=12, assert reset next cycle -> no reg_write, all busy=0, outputs zero.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared widths, the x0 index and requester ids for the writeback scheduler.
package regfile_wb_scheduler_pkg;

  localparam int WB_DATA_W   = 32;
  localparam int WB_ADDR_W   = 5;
  localparam int WB_NUM_REGS = 32;
  localparam int WB_CNT_W    = 2;

  localparam int X0 = 0;

  typedef enum logic {
    REQ_EXE = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter between EXE and MEM writeback requests.
// Combinational grant, registered last-winner; EXE wins the first tie after reset.
module wb_rr_arbiter
  import regfile_wb_scheduler_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic exe_req_i,
  input  logic mem_req_i,
  output logic exe_gnt_o,
  output logic mem_gnt_o
);

  req_id_e rr_last_q, rr_last_d;

  always_comb begin
    exe_gnt_o = exe_req_i && (!mem_req_i || (rr_last_q == REQ_MEM));
    mem_gnt_o = mem_req_i && !exe_gnt_o;
    rr_last_d = rr_last_q;
    if (exe_gnt_o) begin
      rr_last_d = REQ_EXE;
    end else if (mem_gnt_o) begin
      rr_last_d = REQ_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q <= REQ_MEM;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between EXE and MEM writebacks, one cycle
// after grant, and tracks per-register outstanding writes for decode RAW stalls.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DATA_W   = WB_DATA_W,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int NUM_REGS = WB_NUM_REGS,
  parameter int CNT_W    = WB_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              exe_valid,
  input  logic [ADDR_W-1:0] exe_rd,
  input  logic [DATA_W-1:0] exe_data,
  output logic              exe_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] RD_X0  = ADDR_W'(X0);

  logic              exe_gnt, mem_gnt, any_gnt;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              retire_hit;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic [CNT_W-1:0]  cnt_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d [NUM_REGS];

  wb_rr_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .exe_req_i (exe_valid),
    .mem_req_i (mem_valid),
    .exe_gnt_o (exe_gnt),
    .mem_gnt_o (mem_gnt)
  );

  assign exe_ready = exe_gnt;
  assign mem_ready = mem_gnt;
  assign any_gnt   = exe_gnt || mem_gnt;
  assign sel_rd    = exe_gnt ? exe_rd   : mem_rd;
  assign sel_data  = exe_gnt ? exe_data : mem_data;

  // A retiring write frees a slot in the same cycle, so a saturated rd can still issue.
  assign retire_hit  = reg_write_q && (write_addr_q == issue_rd);
  assign issue_ready = (cnt_q[issue_rd] != CNT_MAX) || retire_hit;

  assign rs1_busy = (rs1_addr != RD_X0) && (cnt_q[rs1_addr] != '0);
  assign rs2_busy = (rs2_addr != RD_X0) && (cnt_q[rs2_addr] != '0);

  always_comb begin
    reg_write_d  = any_gnt && (sel_rd != RD_X0);
    write_addr_d = any_gnt ? sel_rd   : write_addr_q;
    write_data_d = any_gnt ? sel_data : write_data_q;
  end

  // x0 is never counted; a retire against an empty counter is ignored rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if ((issue_valid && issue_ready && (issue_rd == ADDR_W'(r))) &&
          !(reg_write_q && (write_addr_q == ADDR_W'(r)) && (cnt_q[r] != '0))) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (!(issue_valid && issue_ready && (issue_rd == ADDR_W'(r))) &&
                   (reg_write_q && (write_addr_q == ADDR_W'(r)) && (cnt_q[r] != '0))) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      cnt_q        <= '{default: '0};
    end else begin
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed scenarios plus randomized traffic checked against a counting reference model.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        exe_valid, mem_valid;
  logic [4:0]  exe_rd, mem_rd;
  logic [31:0] exe_data, mem_data;
  logic        exe_ready, mem_ready;
  logic        reg_write;
  logic [4:0]  write_addr;
  logic [31:0] write_data;

  regfile_wb_scheduler dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .exe_valid(exe_valid), .exe_rd(exe_rd), .exe_data(exe_data), .exe_ready(exe_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding writes per register, the write expected on the port,
  // and which requester won the most recent grant.
  int          cnt_m [32];
  bit          we_m;
  logic [4:0]  addr_m;
  logic [31:0] data_m;
  bit          last_mem_m;
  bit          exe_acc, mem_acc, seen_exe_rdy, seen_issue_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    we_m = 0; addr_m = '0; data_m = '0; last_mem_m = 1;
  endtask

  // Inputs are applied at posedge+1; check combinational outputs, clock, check registers.
  task automatic tick();
    bit g_exe, g_mem, ir;
    #1;
    g_exe = exe_valid && (!mem_valid || last_mem_m);
    g_mem = mem_valid && !g_exe;
    ir    = (cnt_m[issue_rd] < 3) || (we_m && addr_m == issue_rd);
    check("exe_ready", exe_ready, g_exe);
    check("mem_ready", mem_ready, g_mem);
    check("issue_ready", issue_ready, ir);
    check("rs1_busy", rs1_busy, rs1_addr != 0 && cnt_m[rs1_addr] > 0);
    check("rs2_busy", rs2_busy, rs2_addr != 0 && cnt_m[rs2_addr] > 0);
    seen_exe_rdy   = exe_ready;
    seen_issue_rdy = issue_ready;
    exe_acc = g_exe;
    mem_acc = g_mem;
    if (we_m && cnt_m[addr_m] > 0) cnt_m[addr_m]--;
    if (issue_valid && ir && issue_rd != 0) cnt_m[issue_rd]++;
    if (g_exe) begin
      we_m = exe_rd != 0; addr_m = exe_rd; data_m = exe_data; last_mem_m = 0;
    end else if (g_mem) begin
      we_m = mem_rd != 0; addr_m = mem_rd; data_m = mem_data; last_mem_m = 1;
    end else begin
      we_m = 0;
    end
    @(posedge clk);
    #1;
    check("reg_write", reg_write, we_m);
    if (we_m) begin
      check("write_addr", write_addr, addr_m);
      check("write_data", write_data, data_m);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
    exe_valid = 0; exe_rd = '0; exe_data = '0;
    mem_valid = 0; mem_rd = '0; mem_data = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    @(posedge clk);
    #1;
    model_reset();
    reset = 0;
    check("rst_reg_write", reg_write, 0);
    check("rst_write_addr", write_addr, 0);
    check("rst_write_data", write_data, 0);
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single EXE writeback with 1-cycle latency.
    exe_valid = 1; exe_rd = 5'd5; exe_data = 32'hDEADBEEF;
    tick();
    check("t1_exe_ready", seen_exe_rdy, 1);
    check("t1_we", reg_write, 1);
    check("t1_addr", write_addr, 5);
    check("t1_data", write_data, 32'hDEADBEEF);
    exe_valid = 0;
    tick();
    check("t1_we_after", reg_write, 0);

    // Both requesters always valid: grants alternate starting with EXE.
    do_reset();
    exe_valid = 1; exe_rd = 5'd3; mem_valid = 1; mem_rd = 5'd4;
    for (int i = 0; i < 4; i++) begin
      exe_data = $urandom; mem_data = $urandom;
      tick();
      check("alt_exe_grant", seen_exe_rdy, (i % 2) == 0);
      check("alt_addr", write_addr, (i % 2) == 0 ? 3 : 4);
    end
    exe_valid = 0; mem_valid = 0;
    tick();

    // Issue rd=7 makes it busy until the write pulse has been consumed.
    do_reset();
    issue_valid = 1; issue_rd = 5'd7; rs1_addr = 5'd7;
    tick();
    issue_valid = 0;
    check("busy7_set", rs1_busy, 1);
    exe_valid = 1; exe_rd = 5'd7; exe_data = 32'h7777;
    tick();
    exe_valid = 0;
    check("busy7_during_pulse", rs1_busy, 1);
    tick();
    check("busy7_clear", rs1_busy, 0);

    // Saturation at three outstanding writes, and retire+issue on the same register.
    do_reset();
    issue_valid = 1; issue_rd = 5'd9; rs1_addr = 5'd9;
    repeat (3) tick();
    issue_valid = 0;
    #1;
    check("sat_issue_ready", issue_ready, 0);
    exe_valid = 1; exe_rd = 5'd9; exe_data = 32'h99;
    tick();
    exe_valid = 0; issue_valid = 1;
    tick();
    check("retire_issue_ready", seen_issue_rdy, 1);
    issue_valid = 0;
    #1;
    check("count_back_at_3", issue_ready, 0);

    // Writeback to x0 is accepted but never pulses reg_write.
    do_reset();
    rs2_addr = 5'd0;
    exe_valid = 1; exe_rd = 5'd0; exe_data = 32'h1;
    issue_valid = 1; issue_rd = 5'd0;
    tick();
    exe_valid = 0; issue_valid = 0;
    check("x0_exe_ready", seen_exe_rdy, 1);
    check("x0_no_write", reg_write, 0);
    check("x0_busy", rs2_busy, 0);

    // Reset on the cycle a MEM write is accepted drops the write.
    do_reset();
    issue_valid = 1; issue_rd = 5'd12;
    tick();
    issue_valid = 0;
    mem_valid = 1; mem_rd = 5'd12; mem_data = 32'hCAFE0012; rs1_addr = 5'd12;
    reset = 1;
    #1;
    check("rst_mem_ready", mem_ready, 1);
    @(posedge clk);
    #1;
    model_reset();
    reset = 0;
    mem_valid = 0;
    check("rst_drop_we", reg_write, 0);
    check("rst_drop_addr", write_addr, 0);
    check("rst_drop_data", write_data, 0);
    check("rst_drop_busy", rs1_busy, 0);

    // Randomized traffic; requesters hold their request until accepted.
    idle_inputs();
    exe_acc = 0; mem_acc = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!exe_valid || exe_acc) begin
        exe_valid = $urandom_range(0, 9) < 4;
        exe_rd = 5'($urandom_range(0, 7)); exe_data = $urandom;
      end
      if (!mem_valid || mem_acc) begin
        mem_valid = $urandom_range(0, 9) < 4;
        mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
      end
      issue_valid = $urandom_range(0, 1) == 1;
      issue_rd = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
